// File: rtl/chacha_round_engine_if.sv
// chacha_round_engine_if: load request and result handshake bundle for chacha_round_engine
interface chacha_round_engine_if;
  logic start;
  logic [511:0] state_in;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic [511:0] block_out;
  logic busy;
  modport master (output start, state_in, out_ready, input in_ready, out_valid, block_out, busy);
  modport slave (input start, state_in, out_ready, output in_ready, out_valid, block_out, busy);
endinterface

// File: rtl/chacha_round_engine.sv
// chacha_round_engine: sequential ChaCha permutation, QR_LANES quarter-rounds per cycle, valid/ready result.
// Define CHACHA_FEEDFWD_EN to add the input feed-forward (full ChaCha block function, one extra FEED cycle).
module chacha_round_engine #(
  parameter int ROUNDS = 20,
  parameter int QR_LANES = 4
) (
  input logic clock,
  input logic reset_n,
  chacha_round_engine_if.slave bus
);
  localparam int QN = 4 / QR_LANES;
  localparam int RW = $clog2(ROUNDS);
  if (ROUNDS < 2 || ROUNDS % 2 != 0) begin : g_bad_rounds
    $error("chacha_round_engine: ROUNDS must be even and >= 2");
  end
  if (QR_LANES != 1 && QR_LANES != 2 && QR_LANES != 4) begin : g_bad_lanes
    $error("chacha_round_engine: QR_LANES must be 1, 2 or 4");
  end
`ifdef CHACHA_FEEDFWD_EN
  typedef enum logic [1:0] {IDLE, RUN, FEED, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif
  state_t state, state_n;
  logic [511:0] x, x_n, blk;
`ifdef CHACHA_FEEDFWD_EN
  logic [511:0] s;
`endif
  logic [1:0] q, g;
  logic [RW-1:0] r;
  logic [3:0] ia, ib, ic, id;
  logic vld, q_wrap, last;
  function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction
  assign q_wrap = q == 2'(QN - 1);
  assign last = q_wrap && r == RW'(ROUNDS - 1);
  // Odd half-rounds walk the diagonals: row k of group g sits in column (g+k) mod 4.
  always_comb begin
    x_n = x;
    g = '0;
    ia = '0;
    ib = '0;
    ic = '0;
    id = '0;
    for (int l = 0; l < QR_LANES; l++) begin
      g = 2'(int'(q) * QR_LANES + l);
      ia = {2'd0, g};
      ib = {2'd1, r[0] ? g + 2'd1 : g};
      ic = {2'd2, r[0] ? g + 2'd2 : g};
      id = {2'd3, r[0] ? g + 2'd3 : g};
      {x_n[32*ia+:32], x_n[32*ib+:32], x_n[32*ic+:32], x_n[32*id+:32]} =
        qr(x[32*ia+:32], x[32*ib+:32], x[32*ic+:32], x[32*id+:32]);
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.start ? RUN : IDLE;
`ifdef CHACHA_FEEDFWD_EN
      RUN: state_n = last ? FEED : RUN;
      FEED: state_n = DONE;
`else
      RUN: state_n = last ? DONE : RUN;
`endif
      DONE: state_n = bus.out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
`ifdef CHACHA_FEEDFWD_EN
      s <= '0;
`endif
      q <= '0;
      r <= '0;
      blk <= '0;
      vld <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        x <= bus.state_in;
`ifdef CHACHA_FEEDFWD_EN
        s <= bus.state_in;
`endif
        q <= '0;
        r <= '0;
      end
      if (state == RUN) begin
        x <= x_n;
        q <= q_wrap ? 2'd0 : q + 2'd1;
        r <= q_wrap ? r + 1'b1 : r;
      end
`ifdef CHACHA_FEEDFWD_EN
      if (state == FEED) begin
        for (int i = 0; i < 16; i++) blk[32*i+:32] <= x[32*i+:32] + s[32*i+:32];
        vld <= 1'b1;
      end
`else
      if (state == RUN && last) begin
        blk <= x_n;
        vld <= 1'b1;
      end
`endif
      if (state == DONE && bus.out_ready) vld <= 1'b0;
    end
  end
  assign bus.in_ready = state == IDLE;
`ifdef CHACHA_FEEDFWD_EN
  assign bus.busy = state == RUN || state == FEED;
`else
  assign bus.busy = state == RUN;
`endif
  assign bus.out_valid = vld;
  assign bus.block_out = blk;
endmodule

// File: doc/chacha_round_engine.md
# chacha_round_engine

Sequential, parametrised ChaCha permutation engine: accepts a 16-word state, iterates a configurable number of rounds (alternating column/diagonal half-rounds) over a configurable number of quarter-round lanes per cycle, then returns the 512-bit result under a valid/ready handshake. It sits between the key/nonce/counter state builder and the keystream XOR stage. It supersedes the purely combinational single-half-round block.

## Interface
- `ROUNDS`, default 20: total rounds. Must be even and ≥ 2; typical values are 8, 12 and 20. Any other value is an elaboration error.
- `QR_LANES`, default 4: quarter-rounds evaluated per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- `clock` input, 1 bit: single clock, rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request to load `state_in`. Honoured only while `in_ready` = 1.
- `state_in` input, 512 bits: word i (0..15) is at [32i+31:32i]. Words 0-3 are row a, 4-7 row b, 8-11 row c, 12-15 row d.
- `in_ready` output, 1 bit: high only in IDLE.
- `out_valid` output, 1 bit: `block_out` holds a finished block.
- `out_ready` input, 1 bit: consumer accepts the block.
- `block_out` output, 512 bits: result, using the same word packing as `state_in`.
- `busy` output, 1 bit: high in RUN or FEED.

## Operation
- **States:** IDLE → RUN → FEED → DONE → IDLE.
- **IDLE, on `start`:**
  - load the working state `x` and the saved copy `s` from `state_in`;
  - clear the lane counter `q` and the round counter `r`;
  - go to RUN.
- **RUN, every cycle:** apply `QR_LANES` quarter-rounds to `x`. The quarter-round is a += b; d ^= a; d <<<= 16; c += d; b ^= c; b <<<= 12; a += b; d ^= a; d <<<= 8; c += d; b ^= c; b <<<= 7. All additions are mod 2^32.
- **Column half-round** (`r` even) uses word groups (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
- **Diagonal half-round** (`r` odd) uses word groups (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
- **Lane scheduling:** cycle `q` processes groups `q*QR_LANES` .. `q*QR_LANES+QR_LANES-1`.
- **Counters:**
  - `q` wraps at 4/`QR_LANES`; each wrap increments `r`.
  - After the last group of half-round `ROUNDS-1`, go to FEED.
- **FEED:** `block_out` ← `x` + `s`, word-wise mod 2^32. Set `out_valid` and go to DONE.
- **DONE:**
  - Hold `block_out` and `out_valid` stable until `out_valid && out_ready`.
  - On that edge, clear `out_valid` and go to IDLE. `block_out` keeps its value.
- **`start` while not IDLE** is ignored. No queueing.
- **`out_ready`** is don't-care outside DONE.
- **Reset, asserted at any time** (including mid-RUN or in DONE):
  - the FSM goes to IDLE immediately;
  - `x`, `s`, `q`, `r` and `block_out` clear to 0;
  - `out_valid` = 0, `busy` = 0, `in_ready` = 1 once reset releases;
  - the aborted block is discarded.

## Timing
- **Reset values:** `in_ready` = 1, `out_valid` = 0, `busy` = 0, `block_out` = 0.
- **Start edge:** `start` is sampled at edge E0, and `busy` = 1 from E0.
- **RUN duration:** RUN lasts N = `ROUNDS`·4/`QR_LANES` cycles, covering edges E1..EN.
- **Result edge:** FEED is at edge EN+1, and `out_valid` = 1 from EN+1.
- **Latency:** start to valid is N+1 cycles. For 20/4 that is 21 cycles; for 20/1 it is 81; for 8/1 it is 33.
- **Next block:** the earliest next `start` is sampled on the edge after the output handshake. Throughput is one block per N+3 cycles with `out_ready` tied high.
- **Outputs** are all registered; there is no combinational path from inputs to outputs.

## Configuration
- **`CHACHA_FEEDFWD_EN` defined:** FEED is present and behaves as described above. `block_out` = permuted state + input state, i.e. the full ChaCha block function.
- **`CHACHA_FEEDFWD_EN` undefined:**
  - the FEED state and the `s` register are removed;
  - after the last RUN cycle, `block_out` ← `x` directly and `out_valid` is set on that same edge;
  - latency is N cycles;
  - use this build for verifying the raw permutation.

## Test plan
- **RFC 7539 §2.3.2 vector** (build with `CHACHA_FEEDFWD_EN`, `ROUNDS`=20, `QR_LANES`=4):
  - stimulus: `state_in` = 61707865 3320646e 79622d32 6b206574 03020100 07060504 0b0a0908 0f0e0d0c 13121110 17161514 1b1a1918 1f1e1d1c 00000001 09000000 4a000000 00000000;
  - required: `block_out` = e4e7f110 15593bd1 1fdd0f50 c47120a3 c7f4d1c7 0368c033 9aaa2204 4e6cd4c3 466482d2 09aa9f07 05d7c214 a2028bd9 d19c12b5 b94e16de e883d0cb 4e3c50a2, with `out_valid` rising exactly 21 cycles after the start edge.
- **Lane equivalence:** the same vector with `QR_LANES` = 1 and = 2 must give an identical `block_out`. `out_valid` must rise at 81 and 41 cycles respectively.
- **All-zero input:** `state_in` = 0 → `block_out` = 0 in both macro builds. Check `busy`/`in_ready` and that `start` is ignored during RUN.
- **Backpressure:** hold `out_ready` = 0 for 10 cycles after `out_valid`. `block_out` stays stable, `in_ready` = 0, and a `start` pulse is ignored. Then `out_ready` = 1 for one cycle → `out_valid` = 0 and `in_ready` = 1 on the next edge.
- **Reset mid-operation:** pull `reset_n` low at RUN cycle 7. Outputs clear immediately with no clock edge needed. After release, a fresh RFC vector completes correctly with nominal latency.
- **`ROUNDS` = 8 without `CHACHA_FEEDFWD_EN`:** `QR_LANES` = 1 gives `out_valid` after 32 cycles. `block_out` equals the reference-model ChaCha8 permutation of the RFC input state.
